multi_context_regfile: RTL
==========================

// Module: multi_context_regfile
// PURPOSE
//  Parametrised multi-context integer register file for the CPU core.
//  Holds NUM_CTX register sets, generalising the single shadow set to N hardware contexts.
//  Provides NUM_RD read ports and NUM_WR write ports, optional write-to-read bypass, and a
//  background context-clear engine. Also provides a registered debug read port. Sits between decode and writeback.
// PARAMETERS
//  DATA_WIDTH 64  register width in bits
//  REG_NUM    32  registers per context; AW = $clog2(REG_NUM)
//  NUM_CTX    4   register contexts (>=2); CW = max(1,$clog2(NUM_CTX))
//  NUM_RD     3   read ports
//  NUM_WR     2   write ports
//  BYPASS     1   1: a same-cycle write is forwarded to matching reads
//  ZERO_REG   1   1: register 0 reads as zero in every context and ignores writes
// PORTS
//  clk          in  1               clock
//  reset        in  1               synchronous, active-high reset
//  rd_addr      in  NUM_RD*AW       read addresses; port i uses [i*AW +: AW]
//  rd_data      out NUM_RD*DW       read data, combinational, taken from the active context
//  wr_en        in  NUM_WR          per-port write enable
//  wr_addr      in  NUM_WR*AW       write addresses
//  wr_data      in  NUM_WR*DW       write data
//  ctx_sel_valid in 1               context-switch request
//  ctx_sel      in  CW              requested context
//  ctx_sel_ready out 1              switch request may be accepted this cycle
//  ctx_active   out CW              current context
//  clr_valid    in  1               clear-context request
//  clr_ctx      in  CW              context to clear
//  clr_ready    out 1               equals !clr_busy
//  clr_busy     out 1               clear engine running
//  clr_done     out 1               one-cycle pulse when the clear finishes
//  dbg_ctx      in  CW              debug context select
//  dbg_addr     in  AW              debug register address
//  dbg_data     out DW              debug read data, registered
// BEHAVIOUR
//  Reset (synchronous, while reset=1):
//   - All registers in all contexts become 0.
//   - ctx_active=0, clr_busy=0, clr_done=0, dbg_data=0.
//   - clr_ready=1 and ctx_sel_ready=1 from the first cycle after reset.
//   - Reset asserted mid-clear aborts the clear; no clr_done pulse is generated.
//  Writes:
//   - Each write port writes the active context at the clock edge when wr_en[j]=1.
//   - Two ports writing the same address in one cycle: the highest-index port wins.
//   - ZERO_REG=1: writes to address 0 are dropped.
//  Reads:
//   - rd_data shows the stored value of ctx_active with zero latency.
//   - ZERO_REG=1: address 0 returns 0.
//   - BYPASS=1: if any wr_en[j] matches rd_addr[i], return wr_data of the highest-index matching j.
//     Address 0 is never bypassed when ZERO_REG=1.
//  Context switch:
//   - Accepted when ctx_sel_valid && ctx_sel_ready.
//   - ctx_sel_ready = !(clr_busy && ctx_sel==clr_ctx_q).
//   - ctx_active updates at the edge; reads and writes use the new context from the next cycle.
//   - Writes in the accept cycle go to the old context.
//   - A switch to the already-active context is a no-op.
//  Clear engine FSM: IDLE -> CLEAR -> DONE -> IDLE.
//   - IDLE: on clr_valid, latch clr_ctx_q=clr_ctx, set ptr=0, go to CLEAR. clr_busy=1 from the next cycle.
//   - CLEAR: zero register ptr of clr_ctx_q each cycle and increment ptr.
//     After ptr==REG_NUM-1 is cleared, go to DONE. The clear takes REG_NUM cycles.
//   - DONE: clr_done=1 for one cycle, clr_busy=0, return to IDLE.
//   - clr_valid while busy is ignored.
//   - Clearing the active context is legal. An architectural write to the same register in the
//     same cycle beats the clear write. Untouched registers keep their values until the clear reaches them.
//   - A context switch accepted in the clr_valid cycle to the same context is allowed, because
//     clr_busy is still 0 in that cycle.
//  Debug port:
//   - dbg_data <= regs[dbg_ctx][dbg_addr] every cycle, 1-cycle latency, stored value only (no bypass).
//  Widths: no arithmetic except the ptr increment (AW+1 bits internally, so it does not wrap).
// TESTING
//  1. Reset, then write ctx0 x5=0xA5 via port0 -> next cycle rd_addr0=5 reads 0xA5; dbg(0,5)
//     reads 0xA5 one cycle later.
//  2. Same cycle: wr port0 x7=0x11 and port1 x7=0x22 -> x7=0x22. BYPASS=1, rd x7 in that
//     cycle -> 0x22. Write x0=0xFF -> x0 reads 0.
//  3. Write ctx0 x3=1; switch to ctx2 and write x3=2 -> ctx2 reads x3=2; switch back to ctx0
//     -> x3=1.
//  4. ctx1 filled with 0xFFFF..., clr_valid clr_ctx=1 -> clr_busy high 32 cycles, then clr_done
//     pulse. dbg on ctx1 reads all 0; ctx0 unchanged.
//  5. During clear of ctx1: ctx_sel=1 -> ctx_sel_ready=0 until clr_busy falls. A second
//     clr_valid is ignored.
//  6. Clear active ctx0 with a write x31=0x5 in the cycle ptr==31 -> x31=0x5 survives.
//     Reset asserted mid-clear -> all 0, clr_busy=0, no clr_done.

Source files
------------

// File: rtl/multi_context_regfile_if.sv
// Register-file bus: read/write ports, context select, clear and debug.
// master drives requests, slave (the register file) returns data/status.
interface multi_context_regfile_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_NUM    = 32,
  parameter int NUM_CTX    = 4,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = (NUM_CTX > 2) ? $clog2(NUM_CTX) : 1;

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 ctx_sel_valid;
  logic [CW-1:0]        ctx_sel;
  logic                 ctx_sel_ready;
  logic [CW-1:0]        ctx_active;
  logic                 clr_valid;
  logic [CW-1:0]        clr_ctx;
  logic                 clr_ready;
  logic                 clr_busy;
  logic                 clr_done;
  logic [CW-1:0]        dbg_ctx;
  logic [AW-1:0]        dbg_addr;
  logic [DW-1:0]        dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output ctx_sel_valid, ctx_sel, clr_valid, clr_ctx,
    output dbg_ctx, dbg_addr,
    input  rd_data, ctx_sel_ready, ctx_active,
    input  clr_ready, clr_busy, clr_done, dbg_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  ctx_sel_valid, ctx_sel, clr_valid, clr_ctx,
    input  dbg_ctx, dbg_addr,
    output rd_data, ctx_sel_ready, ctx_active,
    output clr_ready, clr_busy, clr_done, dbg_data
  );
endinterface

// File: rtl/multi_context_regfile.sv
// Multi-context integer register file: NUM_CTX sets, multi-port, bypass,
// background clear engine, registered debug read. Ports: clk, reset, bus.
module multi_context_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_NUM    = 32,
  parameter int NUM_CTX    = 4,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic clk,
  input logic reset,
  multi_context_regfile_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = (NUM_CTX > 2) ? $clog2(NUM_CTX) : 1;
  localparam logic [AW:0] LAST = (AW+1)'(REG_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } clr_state_t;

  logic [DW-1:0] regs [NUM_CTX][REG_NUM];
  clr_state_t    state;
  logic [AW:0]   ptr;
  logic [CW-1:0] clr_ctx_q;
  logic          clr_busy_q;
  logic          clr_done_q;
  logic [CW-1:0] ctx_q;
  logic [DW-1:0] dbg_q;
  logic          sel_ready;

  logic [AW-1:0] wa [NUM_WR];
  logic [NUM_WR-1:0] we;
  logic [AW-1:0] ra [NUM_RD];
  logic [DW-1:0] rv [NUM_RD];
  logic [NUM_RD*DW-1:0] rdata;

  assign sel_ready = !(clr_busy_q && bus.ctx_sel == clr_ctx_q);

  // Effective write enables: address 0 is dropped when hard-wired.
  always_comb begin
    we = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = bus.wr_addr[j*AW +: AW];
      we[j] = bus.wr_en[j] &&
              !(ZERO_REG != 0 && wa[j] == '0);
    end
  end

  // Later ports override earlier ones, so the highest index wins.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = bus.rd_addr[i*AW +: AW];
      rv[i] = regs[ctx_q][ra[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && wa[j] == ra[i]) begin
            rv[i] = bus.wr_data[j*DW +: DW];
          end
        end
      end
      if (ZERO_REG != 0 && ra[i] == '0) begin
        rv[i] = '0;
      end
      rdata[i*DW +: DW] = rv[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int r = 0; r < REG_NUM; r++) begin
          regs[c][r] <= '0;
        end
      end
      state      <= S_IDLE;
      ptr        <= '0;
      clr_ctx_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      ctx_q      <= '0;
      dbg_q      <= '0;
    end else begin
      dbg_q      <= regs[bus.dbg_ctx][bus.dbg_addr];
      clr_done_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.clr_valid) begin
            clr_ctx_q  <= bus.clr_ctx;
            ptr        <= '0;
            clr_busy_q <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          regs[clr_ctx_q][ptr[AW-1:0]] <= '0;
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Placed after the clear so an architectural write wins.
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j]) begin
          regs[ctx_q][wa[j]] <= bus.wr_data[j*DW +: DW];
        end
      end
      if (bus.ctx_sel_valid && sel_ready) begin
        ctx_q <= bus.ctx_sel;
      end
    end
  end

  assign bus.rd_data       = rdata;
  assign bus.ctx_sel_ready = sel_ready;
  assign bus.ctx_active    = ctx_q;
  assign bus.clr_ready     = !clr_busy_q;
  assign bus.clr_busy      = clr_busy_q;
  assign bus.clr_done      = clr_done_q;
  assign bus.dbg_data      = dbg_q;
endmodule
